// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, branch-predictor query, imem request/ready handshake,
// one-entry skid buffer behind the decode output register, and redirect flush with stale-response drop.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  output logic [31:0] bp_pc,
  input  logic        bp_predict,
  input  logic [31:0] bp_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_predict,
  output logic [31:0] if_pred_target
);

  typedef enum logic {RUN, DROP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] stale_addr;
  logic        pending;

  logic        sk_valid;
  logic [31:0] sk_instr;
  logic [31:0] sk_pc;
  logic        sk_predict;
  logic [31:0] sk_target;

  logic        accept;
  logic        out_free;
  logic [31:0] pc_seq;
  logic [31:0] redir_aligned;

  assign bp_pc         = pc;
  assign redir_aligned = redirect_pc & 32'hFFFF_FFFC;
  assign pc_seq        = bp_predict ? (bp_target & 32'hFFFF_FFFC) : pc + 32'd4;
  assign out_free      = ~if_valid | ~stall;
  assign accept        = (state == RUN) & imem_req & imem_ready & ~redirect;

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = (state == DROP) ? stale_addr : pc;
    if (nrst) begin
      if (state == DROP) imem_req = 1'b1;
      else               imem_req = pending | ~sk_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state          <= RUN;
      pc             <= RESET_PC;
      stale_addr     <= '0;
      pending        <= 1'b0;
      sk_valid       <= 1'b0;
      sk_instr       <= '0;
      sk_pc          <= '0;
      sk_predict     <= 1'b0;
      sk_target      <= '0;
      if_valid       <= 1'b0;
      if_instr       <= '0;
      if_pc          <= '0;
      if_predict     <= 1'b0;
      if_pred_target <= '0;
    end else if (redirect) begin
      pc       <= redir_aligned;
      if_valid <= 1'b0;
      sk_valid <= 1'b0;
      // A response already in flight must still be absorbed at its original address.
      if (state == DROP) begin
        if (imem_ready) begin
          state   <= RUN;
          pending <= 1'b0;
        end else begin
          pending <= 1'b1;
        end
      end else if (pending && !imem_ready) begin
        stale_addr <= imem_addr;
        state      <= DROP;
        pending    <= 1'b1;
      end else begin
        pending <= 1'b0;
      end
    end else begin
      pending <= imem_req & ~imem_ready;
      if (state == DROP && imem_ready) state <= RUN;
      if (accept) begin
        pc         <= pc_seq;
        sk_instr   <= imem_rdata;
        sk_pc      <= pc;
        sk_predict <= bp_predict;
        sk_target  <= bp_target;
      end
      if (out_free) begin
        if (sk_valid) begin
          if_valid       <= 1'b1;
          if_instr       <= sk_instr;
          if_pc          <= sk_pc;
          if_predict     <= sk_predict;
          if_pred_target <= sk_target;
          sk_valid       <= accept;
        end else if (accept) begin
          if_valid       <= 1'b1;
          if_instr       <= imem_rdata;
          if_pc          <= pc;
          if_predict     <= bp_predict;
          if_pred_target <= bp_target;
        end else begin
          if_valid <= 1'b0;
        end
      end else if (accept) begin
        sk_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized stall/redirect/latency traffic,
// checked against an instruction-stream model built from memory and predictor functions.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        nrst_d = 1'b0;
  logic [31:0] bp_pc;
  logic        bp_predict;
  logic [31:0] bp_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_predict;
  logic [31:0] if_pred_target;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  logic        pred_en = 1'b0;
  logic        force_en = 1'b0;
  logic [31:0] force_pc = '0;
  logic [31:0] force_tgt = '0;
  logic        lat_rand = 1'b0;
  int unsigned lat_fix = 0;
  int unsigned wait_cnt = 0;
  int unsigned cur_lat = 0;

  logic [31:0] exp_next = RST_PC;
  logic        prev_valid = 1'b0, prev_stall = 1'b0, prev_redirect = 1'b0;
  logic        prev_req = 1'b0, prev_ready = 1'b0, prev_out = 1'b0;
  logic [31:0] prev_addr = '0, prev_rpc = '0, prev_if_pc = '0, prev_if_instr = '0;
  int unsigned idle = 0;
  int unsigned consumed = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .bp_pc          (bp_pc),
    .bp_predict     (bp_predict),
    .bp_target      (bp_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_predict     (if_predict),
    .if_pred_target (if_pred_target)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic pred_of(input logic [31:0] a, input logic pen, input logic fen,
                                   input logic [31:0] fpc);
    logic [31:0] h;
    h = memf(a);
    return (fen && a == fpc) || (pen && h[5:4] == 2'b00);
  endfunction

  function automatic logic [31:0] tgt_of(input logic [31:0] a, input logic fen,
                                         input logic [31:0] fpc, input logic [31:0] ftgt);
    logic [31:0] h;
    h = memf(a);
    return (fen && a == fpc) ? ftgt : {16'h0000, h[19:6], 2'b00};
  endfunction

  // Predictor and memory responders
  always_comb begin
    bp_predict = pred_of(bp_pc, pred_en, force_en, force_pc);
    bp_target  = tgt_of(bp_pc, force_en, force_pc, force_tgt);
    imem_ready = imem_req && (wait_cnt >= cur_lat);
    imem_rdata = imem_ready ? memf(imem_addr) : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (!nrst) begin
      wait_cnt <= 0;
      cur_lat  <= lat_fix;
    end else if (imem_req && !imem_ready) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
      cur_lat  <= lat_rand ? $urandom_range(3, 0) : lat_fix;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic auto_check();
    logic outstanding;
    if (!nrst) begin
      exp_next      = RST_PC;
      prev_valid    = 1'b0;
      prev_stall    = 1'b0;
      prev_redirect = 1'b0;
      prev_req      = 1'b0;
      prev_ready    = 1'b0;
      prev_out      = 1'b0;
      idle          = 0;
      return;
    end
    outstanding = prev_req & ~prev_ready & ~(prev_redirect & ~prev_out);
    if (prev_redirect) begin
      check("redir_flush", 32'(if_valid), 32'd0);
      if (!(prev_out & ~prev_ready)) begin
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_addr", imem_addr, prev_rpc & 32'hFFFF_FFFC);
      end
    end
    if (outstanding) begin
      check("req_hold", 32'(imem_req), 32'd1);
      check("addr_hold", imem_addr, prev_addr);
    end
    if (prev_valid & prev_stall & ~prev_redirect) begin
      check("stall_valid", 32'(if_valid), 32'd1);
      check("stall_pc", if_pc, prev_if_pc);
      check("stall_instr", if_instr, prev_if_instr);
    end
    if (if_valid & ~stall) begin
      check("if_pc", if_pc, exp_next);
      check("if_instr", if_instr, memf(exp_next));
      check("if_predict", 32'(if_predict), 32'(pred_of(exp_next, pred_en, force_en, force_pc)));
      check("if_pred_target", if_pred_target, tgt_of(exp_next, force_en, force_pc, force_tgt));
      exp_next = pred_of(exp_next, pred_en, force_en, force_pc)
                 ? tgt_of(exp_next, force_en, force_pc, force_tgt) : exp_next + 32'd4;
      consumed++;
      idle = 0;
    end else if (!stall) begin
      idle++;
      if (idle > 60) begin
        check("progress", 32'(idle), 32'd0);
        idle = 0;
      end
    end
    if (redirect) exp_next = redirect_pc & 32'hFFFF_FFFC;
    prev_valid    = if_valid;
    prev_stall    = stall;
    prev_redirect = redirect;
    prev_req      = imem_req;
    prev_ready    = imem_ready;
    prev_out      = outstanding;
    prev_addr     = imem_addr;
    prev_rpc      = redirect_pc;
    prev_if_pc    = if_pc;
    prev_if_instr = if_instr;
  endtask

  task automatic cyc_start();
    @(posedge clk);
    #1;
    nrst = nrst_d;
  endtask

  task automatic cyc_end(input logic st, input logic rd, input logic [31:0] rpc);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    @(negedge clk);
    auto_check();
  endtask

  task automatic tick(input logic st, input logic rd, input logic [31:0] rpc);
    cyc_start();
    cyc_end(st, rd, rpc);
  endtask

  task automatic do_reset();
    nrst_d = 1'b0;
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_bp_pc", bp_pc, RST_PC);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_predict", 32'(if_predict), 32'd0);
    check("rst_target", if_pred_target, 32'd0);
    nrst_d = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached with %0d/%0d checks done", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    logic found;
    logic [31:0] rpc;

    // Zero-latency sequential fetch, then a 3-cycle stall with the skid filling
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, '0);
      check("seq_addr", imem_addr, RST_PC + 32'(4 * i));
      if (i > 0) check("seq_if_pc", if_pc, RST_PC + 32'(4 * (i - 1)));
    end
    check("seq_pred", 32'(if_predict), 32'd0);
    tick(1'b1, 1'b0, '0);
    check("stall_if_108", if_pc, 32'h108);
    tick(1'b1, 1'b0, '0);
    check("skid_noreq", 32'(imem_req), 32'd0);
    tick(1'b1, 1'b0, '0);
    check("skid_noreq", 32'(imem_req), 32'd0);
    check("stall_if_108", if_pc, 32'h108);
    tick(1'b0, 1'b0, '0);
    check("rel_108", if_pc, 32'h108);
    tick(1'b0, 1'b0, '0);
    check("rel_10c", if_pc, 32'h10C);
    tick(1'b0, 1'b0, '0);
    check("rel_110", if_pc, 32'h110);

    // Predicted-taken at 0x104
    force_en = 1'b1; force_pc = 32'h104; force_tgt = 32'h200;
    do_reset();
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    check("pred_addr", imem_addr, 32'h200);
    check("pred_if_pc", if_pc, 32'h104);
    check("pred_flag", 32'(if_predict), 32'd1);
    check("pred_tgt", if_pred_target, 32'h200);
    tick(1'b0, 1'b0, '0);
    check("pred_follow", if_pc, 32'h200);

    // Latency 3, redirect while the 0x108 request is outstanding
    force_en = 1'b0; lat_fix = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1'b0, 1'b0, '0);
      if (imem_req && imem_addr == 32'h108) found = 1'b1;
    end
    check("find_108", 32'(found), 32'd1);
    tick(1'b0, 1'b1, 32'h400);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b0, 1'b0, '0);
      check("drop_addr", imem_addr, 32'h108);
      check("drop_quiet", 32'(if_valid), 32'd0);
      if (imem_ready) found = 1'b1;
    end
    check("drop_done", 32'(found), 32'd1);
    tick(1'b0, 1'b0, '0);
    check("post_drop_addr", imem_addr, 32'h400);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b0, 1'b0, '0);
      if (if_valid) begin
        check("first_pc_400", if_pc, 32'h400);
        found = 1'b1;
      end
    end
    check("first_seen_400", 32'(found), 32'd1);

    // Redirect coinciding with ready, then redirect again while dropping
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc_start();
      if (imem_ready) begin
        cyc_end(1'b0, 1'b1, 32'h300);
        found = 1'b1;
      end else begin
        cyc_end(1'b0, 1'b0, '0);
      end
    end
    check("rdy_redir", 32'(found), 32'd1);
    tick(1'b0, 1'b0, '0);
    check("rr_addr", imem_addr, 32'h300);
    tick(1'b0, 1'b1, 32'h480);
    tick(1'b0, 1'b1, 32'h500);
    check("drop2_addr", imem_addr, 32'h300);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b0, 1'b0, '0);
      check("drop2_quiet", 32'(if_valid), 32'd0);
      if (imem_ready) found = 1'b1;
    end
    check("drop2_done", 32'(found), 32'd1);
    tick(1'b0, 1'b0, '0);
    check("post2_addr", imem_addr, 32'h500);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b0, 1'b0, '0);
      if (if_valid) begin
        check("first_pc_500", if_pc, 32'h500);
        found = 1'b1;
      end
    end
    check("first_seen_500", 32'(found), 32'd1);

    // PC wrap at the top of the address space
    lat_fix = 0;
    do_reset();
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b1, 32'hFFFF_FFFC);
    tick(1'b0, 1'b0, '0);
    check("wrap_hi", imem_addr, 32'hFFFF_FFFC);
    tick(1'b0, 1'b0, '0);
    check("wrap_lo", imem_addr, 32'h0000_0000);

    // Random traffic: variable latency, stalls, redirects, hashed predictor
    lat_rand = 1'b1; pred_en = 1'b1;
    consumed = 0;
    for (int seg = 0; seg < 3; seg++) begin
      do_reset();
      for (int c = 0; c < 1500; c++) begin
        rpc = $urandom & 32'h0000_0FFF;
        if ($urandom_range(7, 0) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
        tick($urandom_range(9, 0) < 3, $urandom_range(19, 0) == 0, rpc);
      end
    end
    check("throughput", 32'(consumed > 500), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the pipeline. It holds the program counter and queries the branch predictor with the current PC. It fetches instructions over a request/ready instruction-memory handshake and presents them, with the prediction used, to decode. It accepts redirects from the branch-resolution flush and discards stale fetches, including a memory response still in flight when the redirect arrives.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- clk  in  1  clock.
- nrst  in  1  reset, synchronous, active-low.
- bp_pc  out  32  PC presented to the predictor; equals the pc register.
- bp_predict  in  1  predictor says taken for bp_pc.
- bp_target  in  32  predicted target for bp_pc.
- imem_req  out  1  fetch request.
- imem_addr  out  32  word-aligned fetch address.
- imem_ready  in  1  response valid this cycle for the current request; may be the same cycle as the first req.
- imem_rdata  in  32  instruction word; valid when imem_ready.
- redirect  in  1  flush pulse from branch resolution (mispredict).
- redirect_pc  in  32  correct next PC; bits [1:0] ignored.
- stall  in  1  decode cannot take if_* this cycle.
- if_valid  out  1  if_* holds a valid instruction.
- if_instr  out  32  instruction.
- if_pc  out  32  its PC.
- if_predict  out  1  prediction applied at fetch.
- if_pred_target  out  32  predicted target, forwarded for later mispredict check.

## Operation
- Internal state:
  - pc: 32 bits, [1:0] always 0.
  - state: RUN or DROP.
  - pending: a request is outstanding.
  - stale_addr: 32 bits.
  - Output register: if_*.
  - Skid register: sk_valid plus instr, pc, predict and target.
- Request rule: once imem_req is asserted, it and imem_addr stay stable until imem_ready.
  - RUN: imem_req = pending | ~sk_valid; imem_addr = pc.
  - DROP: imem_req = 1; imem_addr = stale_addr.
- Accept: in RUN, a cycle with imem_req & imem_ready & ~redirect.
  - Captured entry = {imem_rdata, pc, bp_predict, bp_target}, with bp_* sampled in the accept cycle.
  - pc <= bp_predict ? bp_target : pc+4. Addition is modulo 2^32, so 32'hFFFF_FFFC+4 = 0.
- Output advance, when the output is free (~if_valid | ~stall):
  - If skid is full, load the output from the skid and clear it.
  - Otherwise, if accept, load the output from the captured entry.
  - Otherwise, if_valid <= 0.
  - If the output is blocked (if_valid & stall) and accept occurs, the entry goes into the skid. Skid full blocks new request starts, so the skid cannot overflow.
- Skid and accept same cycle with the output free: the output takes the skid and the new entry goes into the skid.
- pending <= imem_req & ~imem_ready.
- Redirect has priority over accept, advance and skid in the same cycle:
  - if_valid <= 0; sk_valid <= 0; pc <= {redirect_pc[31:2],2'b00}.
  - If pending & ~imem_ready (response in flight): stale_addr <= current imem_addr; state <= DROP.
  - If imem_ready is high that cycle: the response is discarded and state <= RUN.
- DROP: wait for imem_ready, discard the data, then state <= RUN and pending <= 0.
  - A redirect while in DROP updates pc only; state stays DROP.
- if_* data fields keep their last value when if_valid = 0.

## Timing
- Reset (nrst low at a clock edge): pc = RESET_PC; state = RUN; pending = 0; sk_valid = 0; if_valid = 0; if_instr, if_pc, if_pred_target = 0; if_predict = 0.
  - imem_req is forced to 0 while nrst is low and may rise the first cycle after.
  - Reset mid-request abandons it; memory tolerates the req drop.
- Accept in cycle N gives if_* valid from N+1. New pc is on bp_pc and imem_addr in N+1.
- Zero-latency memory with no stalls sustains 1 instr/cycle. A predicted-taken branch costs no bubble.
- Redirect in cycle N:
  - if_valid = 0 in N+1.
  - If no response is in flight: imem_addr = redirect_pc in N+1.
  - Otherwise: imem_addr = stale_addr until imem_ready, then the redirect PC the cycle after.
- Stall held: if_* stays constant, at most one extra instruction is buffered, and imem_req deasserts after the in-flight request completes.

## Test plan
- Reset with RESET_PC=32'h100, zero-latency memory, predictor never taken → imem_addr 0x100, 0x104, 0x108 on consecutive cycles; if_pc follows one cycle later; if_predict = 0.
- bp_predict=1, bp_target=0x200 at pc 0x104 → next imem_addr 0x200; if_pc=0x104 with if_predict=1 and if_pred_target=0x200.
- Stall for 3 cycles with 0x108 in if_* → if_* stays 0x108; the skid holds 0x10C; no request starts while the skid is full. On release: 0x10C, then 0x110, with no loss or duplication.
- 3-cycle memory latency; redirect to 0x400 one cycle after the request for 0x108 → imem_addr stays 0x108 until ready; that data is never output; next request is 0x400; first valid if_pc is 0x400.
- Redirect in the same cycle as imem_ready, then a second redirect to 0x500 while in DROP → no stale if_valid; the first post-drop fetch is 0x500.
- pc 0xFFFF_FFFC, not taken → next fetch address is 0x0000_0000.
